// File: rtl/dct2_1d_2_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dct2_1d_2_core : column-pass forward 1-D VVC DCT-II, 4/8/16/32 points,     |
// |                  one registered result per clock.                          |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module dct2_1d_2_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   N,
  input  logic [511:0] X_test,
  output logic [511:0] Y
);

  // Magnitude of the 32-point basis at cosine index m (angle pi*m/64), m = 0..32.
  function automatic logic [7:0] cos_mag(input logic [5:0] m);
    logic [7:0] v;
    case (m)
      6'd0, 6'd1, 6'd2, 6'd3: v = 8'd90;
      6'd4:  v = 8'd89;  6'd5:  v = 8'd88;  6'd6:  v = 8'd87;  6'd7:  v = 8'd85;
      6'd8:  v = 8'd83;  6'd9:  v = 8'd82;  6'd10: v = 8'd80;  6'd11: v = 8'd78;
      6'd12: v = 8'd75;  6'd13: v = 8'd73;  6'd14: v = 8'd70;  6'd15: v = 8'd67;
      6'd16: v = 8'd64;  6'd17: v = 8'd61;  6'd18: v = 8'd57;  6'd19: v = 8'd54;
      6'd20: v = 8'd50;  6'd21: v = 8'd46;  6'd22: v = 8'd43;  6'd23: v = 8'd38;
      6'd24: v = 8'd36;  6'd25: v = 8'd31;  6'd26: v = 8'd25;  6'd27: v = 8'd22;
      6'd28: v = 8'd18;  6'd29: v = 8'd13;  6'd30: v = 8'd9;   6'd31: v = 8'd4;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // T32[row][n]: entry depends only on the angle index row*(2n+1) mod 128.
  function automatic logic signed [7:0] coef(input logic [4:0] row, input logic [4:0] n);
    logic [6:0] a;
    logic [5:0] m;
    logic       neg;
    a = 7'({2'b00, row} * {1'b0, n, 1'b1});
    if (a <= 7'd32) begin
      m   = a[5:0];
      neg = 1'b0;
    end else if (a <= 7'd64) begin
      m   = 6'(7'd64 - a);
      neg = 1'b1;
    end else if (a <= 7'd96) begin
      m   = 6'(a - 7'd64);
      neg = 1'b1;
    end else begin
      m   = 6'(8'd128 - {1'b0, a});
      neg = 1'b0;
    end
    if (row == 5'd0) return 8'sd64;
    return neg ? -$signed(cos_mag(m)) : $signed(cos_mag(m));
  endfunction

  logic [5:0]   size;
  logic [3:0]   shamt;
  logic [511:0] y_next;

  assign size  = 6'd4 << N;
  assign shamt = 4'd8 + {2'b00, N};

  for (genvar k = 0; k < 32; k++) begin : g_coef
    logic [4:0]         row;
    logic signed [31:0] acc;
    logic signed [31:0] rnd;
    logic signed [31:0] shifted;
    logic signed [15:0] sat;

    // Rows of the smaller transforms are decimated rows of the 32-point matrix.
    assign row = 5'(k << (2'd3 - N));
    assign rnd = 32'sd1 <<< (shamt - 4'd1);

    always_comb begin
      acc = '0;
      for (int n = 0; n < 32; n++) begin
        if (6'(n) < size)
          acc = acc + 32'($signed(X_test[16*n +: 16])) * 32'(coef(row, 5'(n)));
      end
    end

    always_comb begin
      shifted = (acc + rnd) >>> shamt;
      if (shifted > 32'sd32767)
        sat = 16'sh7fff;
      else if (shifted < -32'sd32768)
        sat = 16'sh8000;
      else
        sat = shifted[15:0];
    end

    assign y_next[16*k +: 16] = (6'(k) < size) ? sat : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      Y <= '0;
    else
      Y <= y_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_dct2_1d_2_core.sv
`default_nettype none
// Directed table vectors, reset corner cases and an alternating-size random run
// for dct2_1d_2_core against an independently derived reference model.
module tb_dct2_1d_2_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   N;
  logic [511:0] X_test;
  logic [511:0] Y;

  int checks = 0;
  int errors = 0;

  dct2_1d_2_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .N      (N),
    .X_test (X_test),
    .Y      (Y)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   n;
    logic [511:0] x;
    logic [511:0] y;
  } vec_t;

  vec_t vq[$];

  // First-column magnitudes of the H.266 32-point matrix, index = cosine angle.
  int ctab[33] = '{90, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67,
                   64, 61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

  function automatic int tcoef(int row, int n);
    int  a, r, m, mag;
    real c;
    if (row == 0) return 64;
    a   = (row * (2 * n + 1)) % 128;
    r   = a % 64;
    m   = (r <= 32) ? r : 64 - r;
    mag = ctab[m];
    c   = $cos(3.14159265358979 * a / 64.0);
    return (c < 0.0) ? -mag : mag;
  endfunction

  function automatic logic [511:0] model(logic [1:0] nsel, logic [511:0] x);
    logic [511:0] r;
    int     m, s;
    longint acc, y;
    r = '0;
    m = 4 << nsel;
    s = 8 + int'(nsel);
    for (int k = 0; k < m; k++) begin
      acc = 0;
      for (int n = 0; n < m; n++)
        acc += longint'($signed(x[16*n +: 16])) * longint'(tcoef(k * (32 / m), n));
      y = (acc + (longint'(1) << (s - 1))) >>> s;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      r[16*k +: 16] = 16'(y);
    end
    return r;
  endfunction

  function automatic logic [511:0] pk(int v[32]);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[16*i +: 16] = 16'(v[i]);
    return r;
  endfunction

  function automatic logic [511:0] rand_x();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic add_vec(string name, logic [1:0] n, int xa[32], int ya[32]);
    vec_t v;
    v.name = name;
    v.n    = n;
    v.x    = pk(xa);
    v.y    = pk(ya);
    vq.push_back(v);
  endtask

  task automatic check(string name, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: Y=%h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int xa[32];
    int ya[32];
    int c8[8]   = '{32, 45, 42, 38, 32, 25, 18, 9};
    int c16[16] = '{64, 90, 89, 87, 83, 80, 75, 70, 64, 57, 50, 43, 36, 25, 18, 9};
    int c4[4]   = '{64, 36, -64, -83};
    logic [511:0] x_hold;

    // Directed vectors with hand-computed results.
    xa = '{default: 0}; ya = '{default: 0};
    for (int i = 0; i < 4; i++) xa[i] = 64;
    ya[0] = 64;
    add_vec("n0_dc64", 2'd0, xa, ya);

    xa = '{default: 100}; ya = '{default: 0}; ya[0] = 100;
    add_vec("n3_dc100", 2'd3, xa, ya);

    xa = '{default: 0}; xa[0] = 256; ya = '{default: 0};
    for (int i = 0; i < 8; i++) ya[i] = c8[i];
    add_vec("n1_impulse", 2'd1, xa, ya);

    xa = '{default: 1000}; for (int i = 0; i < 4; i++) xa[i] = 0; ya = '{default: 0};
    add_vec("n0_tail_ignored", 2'd0, xa, ya);

    xa = '{default: 1000}; for (int i = 0; i < 4; i++) xa[i] = 64;
    ya = '{default: 0}; ya[0] = 64;
    add_vec("n0_dc_with_tail", 2'd0, xa, ya);

    xa = '{default: 0}; xa[0] = 1024; ya = '{default: 0};
    for (int i = 0; i < 16; i++) ya[i] = c16[i];
    add_vec("n2_impulse", 2'd2, xa, ya);

    xa = '{default: 0}; xa[0] = 2048;
    for (int i = 0; i < 32; i++) ya[i] = ctab[i];
    ya[0] = 64;
    add_vec("n3_impulse", 2'd3, xa, ya);

    xa = '{default: 0}; xa[1] = 256; ya = '{default: 0};
    for (int i = 0; i < 4; i++) ya[i] = c4[i];
    add_vec("n0_col1", 2'd0, xa, ya);

    xa = '{default: 32767}; ya = '{default: 0}; ya[0] = 32767;
    add_vec("n3_max", 2'd3, xa, ya);

    xa = '{default: -32768}; ya = '{default: 0}; ya[0] = -32768;
    add_vec("n3_min", 2'd3, xa, ya);

    // Reset holds Y at zero with live inputs, then the first edge after release is valid.
    rst_n  = 1'b0;
    N      = 2'd3;
    X_test = rand_x();
    repeat (3) @(posedge clk);
    #1 check("reset_hold", Y, '0);
    N      = vq[0].n;
    X_test = vq[0].x;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", Y, vq[0].y);

    foreach (vq[i]) begin
      N      = vq[i].n;
      X_test = vq[i].x;
      @(posedge clk);
      #1 check(vq[i].name, Y, vq[i].y);
    end

    // Size toggles every cycle; each result must use only its own cycle's N.
    for (int i = 0; i < 1000; i++) begin
      N      = (i % 2 == 0) ? 2'd0 : 2'd3;
      X_test = rand_x();
      @(posedge clk);
      #1 check("alt_random", Y, model(N, X_test));
    end

    // Mid-stream reset clears Y without waiting for a clock edge.
    N      = 2'd3;
    X_test = vq[6].x;
    @(posedge clk);
    #1 check("pre_async_reset", Y, vq[6].y);
    #2 rst_n = 1'b0;
    #1 check("async_clear", Y, '0);
    @(posedge clk);
    #1 check("reset_edge_hold", Y, '0);
    x_hold = rand_x();
    N      = 2'd1;
    X_test = x_hold;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_first", Y, model(2'd1, x_hold));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct2_1d_2_core.md
DCT2_1D_2_CORE -- requirements
Module: dct2_1d_2

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports named clk and rst_n.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: N  input  2  transform size select: 0=4-pt, 1=8-pt, 2=16-pt, 3=32-pt.
REQ-005 Port: X_test  input  512  32 packed signed 16-bit samples; sample i at bits [16i+15:16i], i=0 at LSBs.
REQ-006 Port: Y  output  512  32 packed signed 16-bit coefficients; coefficient k at bits [16k+15:16k].
REQ-007 No parameters; all widths fixed as above.

Function
REQ-008 SHALL compute the second-pass (column) forward 1-D VVC DCT-II of size M = 4 << N.
REQ-009 Coefficient matrix: T_M[k][n] = T32[k*(32/M)][n], with T32 the H.266 integer 32-point DCT-II matrix (row 0 all 64; row 1 starts 90,90,88,85...).
REQ-010 For k < M: acc_k = sum over n=0..M-1 of T_M[k][n]*x_n; signed products 16x8 bits; accumulator at least 32 bits signed.
REQ-011 Shift s = log2(M)+6 (8, 9, 10, 11 for N=0..3); y_k = (acc_k + 2^(s-1)) >>> s, arithmetic shift.
REQ-012 y_k SHALL be saturated to [-32768, 32767] before packing.
REQ-013 For M < 32, samples n >= M SHALL be ignored, and coefficients k >= M SHALL be output as 0.
REQ-014 Latency: Y SHALL update on every rising clk edge from the X_test and N sampled at that edge; 1 cycle, one new result per cycle, no handshake.
REQ-015 N may change on any cycle; each result SHALL reflect only the N sampled in the same cycle as its X_test.
REQ-016 Implementation MAY use even/odd partial butterflies or direct multiply-accumulate; results SHALL be bit-exact with REQ-010..REQ-013.

Reset
REQ-017 While rst_n = 0, Y SHALL be 0 regardless of clk.
REQ-018 Reset assertion mid-stream SHALL clear Y immediately; first valid Y SHALL appear at the first rising edge after rst_n deasserts.

Verification
REQ-019 Reset: rst_n=0 with nonzero X_test -> Y = 0; release rst_n -> next edge produces the correct transform.
REQ-020 N=0, x0..x3=64 -> y0=64, y1..y31=0.
REQ-021 N=3, all 32 samples=100 -> y0=100, y1..y31=0.
REQ-022 N=1, x0=256, others 0 -> y0..y7 = 32,45,42,38,32,25,18,9; y8..y31=0.
REQ-023 N=0, x0..x3=0, x4..x31=1000 -> Y = 0, confirming unused samples are ignored.
REQ-024 Back-to-back: N alternating 0,3 each cycle with random X_test against a bit-exact model -> every cycle matches with 1-cycle latency, zero mismatches over >=1000 vectors.
